// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, flush-to-bubble,
// optional 2-entry skid buffer and saturating stall/bubble counters.
module pipe_stage_skid #(
  parameter int unsigned      WIDTH     = 128,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter bit               SKID      = 1'b1,
  parameter int unsigned      CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 up_valid,
  input  logic [WIDTH-1:0]     up_data,
  output logic                 up_ready,
  output logic                 dn_valid,
  output logic [WIDTH-1:0]     dn_data,
  input  logic                 dn_ready,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] bubble_count
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FULL,
    ST_SKID
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] head_next;
  logic [WIDTH-1:0] skid_data;
  logic [WIDTH-1:0] skid_next;
  logic             up_fire;
  logic             dn_fire;

  assign dn_valid = (state != ST_EMPTY);
  assign dn_data  = dn_valid ? head : NOP_VALUE;
  assign up_fire  = up_valid & up_ready;
  assign dn_fire  = dn_valid & dn_ready;

  generate
    if (SKID) begin : g_skid
      // Ready is registered from the next state, so dn_ready never reaches up_ready combinationally.
      logic ready_q;

      always_ff @(posedge clock) begin
        if (reset) begin
          ready_q <= 1'b1;
        end else begin
          ready_q <= (state_next != ST_SKID);
        end
      end

      assign up_ready = ready_q;
    end else begin : g_pass
      assign up_ready = ~dn_valid | dn_ready;
    end
  endgenerate

  always_comb begin
    state_next = state;
    head_next  = head;
    skid_next  = skid_data;
    unique case (state)
      ST_EMPTY: begin
        if (up_fire) begin
          state_next = ST_FULL;
          head_next  = up_data;
        end
      end
      ST_FULL: begin
        if (up_fire && dn_fire) begin
          head_next = up_data;
        end else if (up_fire) begin
          // Only reachable with the skid present: without it, up_fire in FULL implies dn_fire.
          state_next = ST_SKID;
          skid_next  = up_data;
        end else if (dn_fire) begin
          state_next = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (dn_fire) begin
          state_next = ST_FULL;
          head_next  = skid_data;
        end
      end
      default: begin
        state_next = ST_EMPTY;
      end
    endcase
    if (flush) begin
      state_next = ST_EMPTY;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_EMPTY;
      head      <= NOP_VALUE;
      skid_data <= NOP_VALUE;
    end else begin
      state     <= state_next;
      head      <= head_next;
      skid_data <= skid_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (dn_valid && !dn_ready && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_WIDTH'(1);
      end
      if (!dn_valid && dn_ready && (bubble_count != '1)) begin
        bubble_count <= bubble_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: skid variant, pass-through variant
// and a narrow-counter variant, each with its own expected-beat queue and monitor.
module tb_pipe_stage_skid;

  localparam int unsigned W     = 8;
  localparam logic [W-1:0] NOP  = 8'hEE;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // DUT A: skid, 16-bit counters
  logic         reset_a, flush_a, up_valid_a, up_ready_a, dn_valid_a, dn_ready_a;
  logic [W-1:0] up_data_a, dn_data_a;
  logic [15:0]  stall_a, bubble_a;
  // DUT B: no skid
  logic         reset_b, flush_b, up_valid_b, up_ready_b, dn_valid_b, dn_ready_b;
  logic [W-1:0] up_data_b, dn_data_b;
  logic [15:0]  stall_b, bubble_b;
  // DUT C: skid, 4-bit counters
  logic         reset_c, flush_c, up_valid_c, up_ready_c, dn_valid_c, dn_ready_c;
  logic [W-1:0] up_data_c, dn_data_c;
  logic [3:0]   stall_c, bubble_c;

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  logic [W-1:0] qc[$];
  int pops_b = 0;

  pipe_stage_skid #(.WIDTH(W), .NOP_VALUE(NOP), .SKID(1'b1), .CNT_WIDTH(16)) u_a (
    .clock(clock), .reset(reset_a), .flush(flush_a),
    .up_valid(up_valid_a), .up_data(up_data_a), .up_ready(up_ready_a),
    .dn_valid(dn_valid_a), .dn_data(dn_data_a), .dn_ready(dn_ready_a),
    .stall_count(stall_a), .bubble_count(bubble_a));

  pipe_stage_skid #(.WIDTH(W), .NOP_VALUE(NOP), .SKID(1'b0), .CNT_WIDTH(16)) u_b (
    .clock(clock), .reset(reset_b), .flush(flush_b),
    .up_valid(up_valid_b), .up_data(up_data_b), .up_ready(up_ready_b),
    .dn_valid(dn_valid_b), .dn_data(dn_data_b), .dn_ready(dn_ready_b),
    .stall_count(stall_b), .bubble_count(bubble_b));

  pipe_stage_skid #(.WIDTH(W), .NOP_VALUE(NOP), .SKID(1'b1), .CNT_WIDTH(4)) u_c (
    .clock(clock), .reset(reset_c), .flush(flush_c),
    .up_valid(up_valid_c), .up_data(up_data_c), .up_ready(up_ready_c),
    .dn_valid(dn_valid_c), .dn_data(dn_data_c), .dn_ready(dn_ready_c),
    .stall_count(stall_c), .bubble_count(bubble_c));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Monitors sample at negedge: inputs are stable, and a seen fire happens at the next posedge.
  always @(negedge clock) begin
    if (!reset_a) begin
      if (!dn_valid_a) check("a_bubble_nop", dn_data_a, NOP);
      if (dn_valid_a && dn_ready_a) begin
        if (qa.size() == 0) begin
          check("a_unexpected_beat", dn_data_a, 32'hFFFF_FFFF);
        end else begin
          check("a_beat", dn_data_a, qa.pop_front());
        end
      end
    end
  end

  always @(negedge clock) begin
    if (!reset_b) begin
      if (!dn_valid_b) check("b_bubble_nop", dn_data_b, NOP);
      if (dn_valid_b && dn_ready_b) begin
        pops_b++;
        if (qb.size() == 0) begin
          check("b_unexpected_beat", dn_data_b, 32'hFFFF_FFFF);
        end else begin
          check("b_beat", dn_data_b, qb.pop_front());
        end
      end
    end
  end

  always @(negedge clock) begin
    if (!reset_c) begin
      if (dn_valid_c && dn_ready_c) begin
        if (qc.size() == 0) begin
          check("c_unexpected_beat", dn_data_c, 32'hFFFF_FFFF);
        end else begin
          check("c_beat", dn_data_c, qc.pop_front());
        end
      end
    end
  end

  initial begin
    {reset_a, reset_b, reset_c} = 3'b111;
    {flush_a, flush_b, flush_c} = 3'b000;
    {up_valid_a, up_valid_b, up_valid_c} = 3'b000;
    {dn_ready_a, dn_ready_b, dn_ready_c} = 3'b000;
    up_data_a = '0; up_data_b = '0; up_data_c = '0;
    repeat (2) cyc();
    {reset_a, reset_b, reset_c} = 3'b000;

    // Reset state
    check("rst_up_ready", up_ready_a, 1);
    check("rst_dn_valid", dn_valid_a, 0);
    check("rst_dn_data", dn_data_a, NOP);
    check("rst_stall", stall_a, 0);
    check("rst_bubble", bubble_a, 0);

    // Single beat, one-cycle latency
    up_valid_a = 1; up_data_a = 8'hA1; dn_ready_a = 1; qa.push_back(8'hA1);
    cyc();
    check("lat_dn_valid", dn_valid_a, 1);
    check("lat_dn_data", dn_data_a, 8'hA1);
    check("lat_stall", stall_a, 0);
    check("lat_bubble", bubble_a, 1);
    up_valid_a = 0;
    cyc();
    check("lat_drained", dn_valid_a, 0);

    // Back-pressure into the skid
    up_valid_a = 1; up_data_a = 8'h01; dn_ready_a = 0; qa.push_back(8'h01);
    cyc();
    check("skid_ready_full", up_ready_a, 1);
    up_data_a = 8'h02; qa.push_back(8'h02);
    cyc();
    check("skid_ready_low", up_ready_a, 0);
    check("skid_stall1", stall_a, 1);
    up_data_a = 8'h03;
    cyc();
    cyc();
    check("skid_stall3", stall_a, 3);
    check("skid_ready_held", up_ready_a, 0);
    check("skid_head_held", dn_data_a, 8'h01);
    dn_ready_a = 1;
    cyc();
    check("skid_ready_back", up_ready_a, 1);
    check("skid_head2", dn_data_a, 8'h02);
    check("skid_stall_frozen", stall_a, 3);
    qa.push_back(8'h03);
    cyc();
    up_valid_a = 0;
    cyc();
    check("skid_drained", dn_valid_a, 0);
    check("skid_bubble", bubble_a, 1);

    // Flush while in skid state, beat 0x55 offered alongside
    up_valid_a = 1; up_data_a = 8'h10; dn_ready_a = 0;
    cyc();
    up_data_a = 8'h20;
    cyc();
    check("flush_pre_ready", up_ready_a, 0);
    flush_a = 1; up_data_a = 8'h55;
    cyc();
    flush_a = 0; up_valid_a = 0;
    check("flush_dn_valid", dn_valid_a, 0);
    check("flush_dn_data", dn_data_a, NOP);
    check("flush_up_ready", up_ready_a, 1);
    check("flush_stall_kept", stall_a, 5);
    up_valid_a = 1; up_data_a = 8'h66; dn_ready_a = 1; qa.push_back(8'h66);
    cyc();
    up_valid_a = 0;
    cyc();
    dn_ready_a = 0;
    check("flush_after_bubble", bubble_a, 2);
    check("flush_after_empty", dn_valid_a, 0);

    // Reset together with flush in skid state
    up_valid_a = 1; up_data_a = 8'h77;
    cyc();
    up_data_a = 8'h88;
    cyc();
    check("rst2_pre_ready", up_ready_a, 0);
    check("rst2_pre_stall", stall_a, 6);
    reset_a = 1; flush_a = 1; up_data_a = 8'h99;
    cyc();
    reset_a = 0; flush_a = 0; up_valid_a = 0;
    check("rst2_dn_valid", dn_valid_a, 0);
    check("rst2_dn_data", dn_data_a, NOP);
    check("rst2_up_ready", up_ready_a, 1);
    check("rst2_stall", stall_a, 0);
    check("rst2_bubble", bubble_a, 0);
    repeat (2) cyc();

    // No-skid variant: full throughput, combinational ready
    up_valid_b = 1; dn_ready_b = 1;
    for (int i = 0; i < 5; i++) begin
      up_data_b = 8'hB0 + 8'(i);
      #1;
      check("pass_up_ready", up_ready_b, 1);
      qb.push_back(up_data_b);
      cyc();
    end
    up_valid_b = 0; dn_ready_b = 0;
    #1;
    check("pass_ready_comb_low", up_ready_b, 0);
    dn_ready_b = 1;
    #1;
    check("pass_ready_comb_high", up_ready_b, 1);
    cyc();
    check("pass_drained", dn_valid_b, 0);
    check("pass_pops", pops_b, 5);
    dn_ready_b = 0;

    // Narrow counters saturate
    up_valid_c = 1; up_data_c = 8'h3C; qc.push_back(8'h3C);
    cyc();
    up_valid_c = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (i == 10) check("sat_stall10", stall_c, 10);
    end
    check("sat_stall", stall_c, 15);
    check("sat_held_valid", dn_valid_c, 1);
    check("sat_held_data", dn_data_c, 8'h3C);
    dn_ready_c = 1;
    cyc();
    repeat (20) cyc();
    check("sat_bubble", bubble_c, 15);
    check("sat_stall_after", stall_c, 15);
    dn_ready_c = 0;
    cyc();

    check("qa_empty", qa.size(), 0);
    check("qb_empty", qb.size(), 0);
    check("qc_empty", qc.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
